tl_fifo_wr_arb: RTL and testbench

TL_FIFO_WR_ARB -- requirements
Module: tl_fifo_wr_arb

---
 rtl/tl_fifo_wr_arb.sv | 62 ++++++
 tb/tb_tl_fifo_wr_arb.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/tl_fifo_wr_arb.sv
// tl_fifo_wr_arb: round-robin packet-locked arbiter feeding one downstream FIFO write port
module tl_fifo_wr_arb #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 256,
  parameter int MAX_BEATS  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid_i,
  input  logic [N_REQ-1:0]            req_last_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [N_REQ-1:0]            req_ready_o,
  input  logic                        fifo_full_i,
  output logic                        fifo_wren_o,
  output logic [DATA_WIDTH-1:0]       fifo_wdata_o,
  output logic [$clog2(N_REQ)-1:0]    grant_o,
  output logic                        busy_o,
  output logic [15:0]                 pkt_cnt_o,
  output logic                        err_o
);
  localparam int GW = $clog2(N_REQ);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t state;
  logic [GW-1:0] grant, rr_ptr, pick;
  logic [4:0] beat_cnt;
  logic acc;
  always_comb begin
    pick = rr_ptr;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req_valid_i[(int'(rr_ptr) + i) % N_REQ]) pick = GW'((int'(rr_ptr) + i) % N_REQ);
  end
  assign busy_o       = state == LOCK;
  assign acc          = busy_o & req_valid_i[grant] & ~fifo_full_i;
  assign fifo_wren_o  = acc;
  assign req_ready_o  = (busy_o & ~fifo_full_i) ? {{(N_REQ-1){1'b0}}, 1'b1} << grant : '0;
  assign fifo_wdata_o = req_data_i[grant*DATA_WIDTH +: DATA_WIDTH];
  assign grant_o      = grant;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      pkt_cnt_o <= '0;
      err_o     <= 1'b0;
    end else if (state == IDLE) begin
      if (|req_valid_i) begin
        grant    <= pick;
        beat_cnt <= '0;
        state    <= LOCK;
      end
    end else if (acc) begin
      beat_cnt <= (beat_cnt == 5'd31) ? beat_cnt : beat_cnt + 5'd1;
      err_o    <= err_o | (beat_cnt == 5'(MAX_BEATS));
      if (req_last_i[grant]) begin
        state     <= IDLE;
        rr_ptr    <= (grant == GW'(N_REQ - 1)) ? '0 : grant + 1'b1;
        pkt_cnt_o <= pkt_cnt_o + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_tl_fifo_wr_arb.sv
// tb_tl_fifo_wr_arb: directed scoreboard bench for tl_fifo_wr_arb
module tb_tl_fifo_wr_arb;
  localparam int N = 4, DW = 32, GW = 2;
  logic clk = 0, rst = 1, fifo_full = 0;
  logic [N-1:0] req_valid, req_last, req_ready, acc;
  logic [N*DW-1:0] req_data;
  logic fifo_wren, busy, err;
  logic [DW-1:0] fifo_wdata;
  logic [GW-1:0] grant;
  logic [15:0] pkt_cnt;
  int rem[N], bidx[N], pid[N];
  bit single[N];
  logic [GW+DW-1:0] exq[$];
  int wr_cyc[$];
  int checks = 0, failures = 0, cyc = 0;

  tl_fifo_wr_arb #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BEATS(16)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_last_i(req_last),
    .req_data_i(req_data), .req_ready_o(req_ready), .fifo_full_i(fifo_full),
    .fifo_wren_o(fifo_wren), .fifo_wdata_o(fifo_wdata), .grant_o(grant),
    .busy_o(busy), .pkt_cnt_o(pkt_cnt), .err_o(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) acc = req_valid & req_ready;

  function automatic logic [DW-1:0] dat(int k, int p, int b);
    return {8'(k), 8'(p), 16'(b)};
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      req_valid[k] = rem[k] > 0;
      req_last[k]  = single[k] || rem[k] == 1;
      req_data[k*DW +: DW] = dat(k, pid[k], bidx[k]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++)
      if (acc[k]) begin
        rem[k]--;
        bidx[k]++;
      end
    drive();
  endtask

  task automatic load(int k, int p, int n, bit s);
    rem[k] = n; bidx[k] = 0; pid[k] = p; single[k] = s;
    drive();
  endtask

  task automatic expb(int k, int p, int b);
    exq.push_back({GW'(k), dat(k, p, b)});
  endtask

  function automatic bit pending();
    for (int k = 0; k < N; k++) if (rem[k] > 0) return 1;
    return 0;
  endfunction

  task automatic wait_done(int budget);
    int n = 0;
    while (pending() && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) chk("timeout", 1, 0);
    tick();
  endtask

  task automatic wait_bidx(int k, int b);
    int n = 0;
    while (bidx[k] < b && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("timeout_bidx", 1, 0);
  endtask

  task automatic chk_gaps(string nm, int cnt, int gap);
    chk({nm, "_count"}, wr_cyc.size(), cnt);
    for (int i = 1; i < wr_cyc.size(); i++) chk({nm, "_gap"}, wr_cyc[i] - wr_cyc[i-1], gap);
  endtask

  always @(negedge clk)
    if (!rst) begin
      if (fifo_full) chk("wren_while_full", fifo_wren, 0);
      if (fifo_wren) begin
        if (exq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: data %0h grant %0d with empty scoreboard", fifo_wdata, grant);
        end else begin
          logic [GW+DW-1:0] e;
          e = exq.pop_front();
          chk("wr_data", fifo_wdata, e[DW-1:0]);
          chk("wr_grant", grant, e[DW +: GW]);
        end
        wr_cyc.push_back(cyc);
      end
    end

  initial begin
    for (int k = 0; k < N; k++) begin rem[k] = 0; bidx[k] = 0; pid[k] = 0; single[k] = 0; end
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0); chk("rst_ready", req_ready, 0); chk("rst_wren", fifo_wren, 0);
    chk("rst_grant", grant, 0); chk("rst_pkt", pkt_cnt, 0); chk("rst_err", err, 0);
    rst = 0;
    // two single-beat packets, req0 then req2
    wr_cyc.delete();
    load(0, 0, 1, 0); load(2, 0, 1, 0);
    expb(0, 0, 0); expb(2, 0, 0);
    @(negedge clk);
    chk("bubble_busy", busy, 0); chk("bubble_wren", fifo_wren, 0); chk("bubble_ready", req_ready, 0);
    tick();
    @(negedge clk);
    chk("t1_busy", busy, 1); chk("t1_grant", grant, 0); chk("t1_wren", fifo_wren, 1);
    wait_done(20);
    chk("t1_pkt", pkt_cnt, 2);
    chk_gaps("t1", 2, 2);
    // 3-beat packet on req1 locks out req0
    wr_cyc.delete();
    load(1, 1, 3, 0);
    expb(1, 1, 0); expb(1, 1, 1); expb(1, 1, 2); expb(0, 1, 0);
    tick();
    load(0, 1, 1, 0);
    wait_done(20);
    chk("t2_pkt", pkt_cnt, 4);
    chk("t2_count", wr_cyc.size(), 4);
    if (wr_cyc.size() == 4) begin
      chk("t2_gap0", wr_cyc[1] - wr_cyc[0], 1);
      chk("t2_gap1", wr_cyc[2] - wr_cyc[1], 1);
      chk("t2_gap2", wr_cyc[3] - wr_cyc[2], 2);
    end
    chk("t2_sb_empty", exq.size(), 0);
    // FIFO full for 4 cycles mid-packet
    load(1, 2, 4, 0);
    for (int b = 0; b < 4; b++) expb(1, 2, b);
    wait_bidx(1, 2);
    fifo_full = 1;
    repeat (4) begin
      @(negedge clk);
      chk("full_ready", req_ready, 0);
      chk("full_wren", fifo_wren, 0);
      tick();
    end
    fifo_full = 0;
    wait_done(20);
    chk("t3_pkt", pkt_cnt, 5);
    chk("t3_sb_empty", exq.size(), 0);
    // 17-beat over-length packet on req2
    load(2, 3, 17, 0);
    for (int b = 0; b < 17; b++) expb(2, 3, b);
    wait_bidx(2, 16);
    @(negedge clk);
    chk("t4_err_before", err, 0);
    wait_done(40);
    chk("t4_err", err, 1);
    chk("t4_pkt", pkt_cnt, 6);
    tick();
    chk("t4_err_sticky", err, 1);
    chk("t4_sb_empty", exq.size(), 0);
    // reset mid-packet on req3
    load(3, 4, 4, 0);
    expb(3, 4, 0); expb(3, 4, 1);
    wait_bidx(3, 2);
    rst = 1;
    #1;
    chk("mid_rst_busy", busy, 0); chk("mid_rst_ready", req_ready, 0); chk("mid_rst_wren", fifo_wren, 0);
    chk("mid_rst_grant", grant, 0); chk("mid_rst_pkt", pkt_cnt, 0); chk("mid_rst_err", err, 0);
    for (int k = 0; k < N; k++) rem[k] = 0;
    drive();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 0;
    chk("t5_pkt_zero", pkt_cnt, 0);
    chk("t5_sb_empty", exq.size(), 0);
    wr_cyc.delete();
    load(3, 5, 1, 0); load(0, 5, 1, 0);
    expb(0, 5, 0); expb(3, 5, 0);
    tick();
    @(negedge clk);
    chk("t5_grant", grant, 0); chk("t5_busy", busy, 1);
    wait_done(20);
    chk("t5_pkt", pkt_cnt, 2);
    // all requesters continuously valid with single-beat packets
    wr_cyc.delete();
    for (int k = 0; k < N; k++) load(k, 6, 2, 1);
    for (int b = 0; b < 2; b++) for (int k = 0; k < N; k++) expb(k, 6, b);
    wait_done(60);
    chk_gaps("t6", 8, 2);
    chk("t6_pkt", pkt_cnt, 10);
    chk("final_sb_empty", exq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
